// File: rtl/pc_fetch_unit.sv
// Program counter with a warm-up phase, redirect handling, alignment error
// pulses and a sticky stall watchdog.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int unsigned WARM_CYCLES = 1,
  parameter int unsigned STALL_MAX   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCEn,
  input  logic        Redirect,
  input  logic [31:0] Target,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Warm,
  output logic        Flush,
  output logic        AlignErr,
  output logic        StallTimeout
);

  localparam int unsigned WarmW = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
  localparam logic [WarmW-1:0] WarmLast = WarmW'((WARM_CYCLES > 0) ? WARM_CYCLES - 1 : 0);
  localparam logic [7:0] StallMax = 8'(STALL_MAX);

  typedef enum logic [1:0] {StWarm, StRun, StStall} state_e;

  // With no warm-up requested the unit comes out of reset already running.
  localparam state_e ResetState = (WARM_CYCLES == 0) ? StRun : StWarm;

  state_e           r_state, w_state_d;
  logic [31:0]      r_pc, w_pc_d;
  logic [31:0]      w_pc_plus4;
  logic [WarmW-1:0] r_warm_cnt, w_warm_cnt_d;
  logic [7:0]       r_stall_cnt, w_stall_cnt_d;
  logic             r_flush, w_flush_d;
  logic             r_align, w_align_d;
  logic             r_timeout, w_timeout_d;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ResetState;
      r_pc        <= RESET_VEC;
      r_warm_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush     <= 1'b0;
      r_align     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_warm_cnt  <= w_warm_cnt_d;
      r_stall_cnt <= w_stall_cnt_d;
      r_flush     <= w_flush_d;
      r_align     <= w_align_d;
      r_timeout   <= w_timeout_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_warm_cnt_d  = r_warm_cnt;
    w_stall_cnt_d = r_stall_cnt;
    w_flush_d     = 1'b0;
    w_align_d     = 1'b0;
    w_timeout_d   = r_timeout;
    unique case (r_state)
      StWarm: begin
        // Control inputs are not trusted yet, so they are never looked at here.
        w_pc_d = w_pc_plus4;
        if (r_warm_cnt == WarmLast) begin
          w_state_d = StRun;
        end else begin
          w_warm_cnt_d = r_warm_cnt + 1'b1;
        end
      end
      StRun, StStall: begin
        // An unknown PCEn falls through to the hold branch.
        if (PCEn) begin
          w_state_d     = StRun;
          w_stall_cnt_d = '0;
          if (Redirect) begin
            w_pc_d    = {Target[31:2], 2'b00};
            w_flush_d = 1'b1;
            w_align_d = |Target[1:0];
          end else begin
            w_pc_d = w_pc_plus4;
          end
        end else begin
          w_state_d = StStall;
          if (r_stall_cnt != StallMax) begin
            w_stall_cnt_d = r_stall_cnt + 8'd1;
          end
          if (r_stall_cnt + 8'd1 == StallMax) begin
            w_timeout_d = 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StRun;
      end
    endcase
  end

  assign PC           = r_pc;
  assign PCPlus4      = w_pc_plus4;
  assign Warm         = (r_state == StWarm);
  assign Flush        = r_flush;
  assign AlignErr     = r_align;
  assign StallTimeout = r_timeout;

endmodule
